gray_pointer_sync: RTL and testbench



---
 rtl/gray_pointer_sync.sv | 81 ++++++++
 tb/tb_gray_pointer_sync.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/gray_pointer_sync.sv
// Destination-side synchroniser for a Gray-coded FIFO pointer, with binary conversion, move delta and refill flag.
// Latency: gray_pointer_o after SYNC_STAGES edges, binary/delta/changed one edge later; no backpressure (samples every edge).
module gray_pointer_sync #(
    parameter int ADDRESS_SIZE = 3,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [ADDRESS_SIZE:0] gray_pointer_i,
    output logic [ADDRESS_SIZE:0] gray_pointer_o,
    output logic [ADDRESS_SIZE:0] binary_pointer_o,
    output logic                  pointer_changed_o,
    output logic [ADDRESS_SIZE:0] delta_o,
    output logic                  sync_valid_o
);

    localparam int W  = ADDRESS_SIZE + 1;
    localparam int CW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] FILL_DONE = CW'(SYNC_STAGES + 1);
    localparam logic [CW-1:0] FILL_LAST = CW'(SYNC_STAGES);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 8) begin : g_bad_stages
            $error("gray_pointer_sync: SYNC_STAGES must be in 2..8");
        end
    endgenerate

    logic [W-1:0]  sync_q [SYNC_STAGES];
    logic [W-1:0]  bin_c;
    logic [CW-1:0] fill_cnt;

    // Plain flop chain: stage 0 is the only flop that sees the foreign-domain bus.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= gray_pointer_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign gray_pointer_o = sync_q[SYNC_STAGES-1];

    always_comb begin
        bin_c        = '0;
        bin_c[W-1]   = gray_pointer_o[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            bin_c[i] = bin_c[i+1] ^ gray_pointer_o[i];
        end
    end

    // Delta wraps modulo 2^W, so a multi-code jump or a wrap through zero reports the true distance.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            binary_pointer_o  <= '0;
            delta_o           <= '0;
            pointer_changed_o <= 1'b0;
        end else begin
            binary_pointer_o  <= bin_c;
            delta_o           <= bin_c - binary_pointer_o;
            pointer_changed_o <= (bin_c != binary_pointer_o);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fill_cnt     <= '0;
            sync_valid_o <= 1'b0;
        end else begin
            if (fill_cnt != FILL_DONE) begin
                fill_cnt <= fill_cnt + CW'(1);
            end
            sync_valid_o <= sync_valid_o | (fill_cnt == FILL_LAST);
        end
    end

endmodule

// File: tb/tb_gray_pointer_sync.sv
// Bench for gray_pointer_sync: two instances (2 and 4 stages) driven from one vector table, checked through per-instance scoreboards.
module tb_gray_pointer_sync;

    typedef struct {
        logic [3:0] gray;
        logic [3:0] bin;
        logic [3:0] delta;
        logic       chg;
    } vec_t;

    typedef struct {
        logic [3:0] gray;
        logic [3:0] bin;
        logic [3:0] delta;
        logic       chg;
        int         due;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] gray_in = '0;

    logic [3:0] g_o [2];
    logic [3:0] b_o [2];
    logic [3:0] d_o [2];
    logic       c_o [2];
    logic       v_o [2];

    sb_t  sbq [2][$];
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [$];

    always #5 clk = ~clk;

    gray_pointer_sync #(.ADDRESS_SIZE(3), .SYNC_STAGES(2)) dut_s2 (
        .clk_i            (clk),
        .reset_i          (rst),
        .gray_pointer_i   (gray_in),
        .gray_pointer_o   (g_o[0]),
        .binary_pointer_o (b_o[0]),
        .pointer_changed_o(c_o[0]),
        .delta_o          (d_o[0]),
        .sync_valid_o     (v_o[0])
    );

    gray_pointer_sync #(.ADDRESS_SIZE(3), .SYNC_STAGES(4)) dut_s4 (
        .clk_i            (clk),
        .reset_i          (rst),
        .gray_pointer_i   (gray_in),
        .gray_pointer_o   (g_o[1]),
        .binary_pointer_o (b_o[1]),
        .pointer_changed_o(c_o[1]),
        .delta_o          (d_o[1]),
        .sync_valid_o     (v_o[1])
    );

    function automatic int stg(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    task automatic chk(input string name, input int d, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (stages=%0d, edge=%0d): got %0d, expected %0d",
                     name, stg(d), edge_cnt, act, exp);
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            chk("sync_valid", d, int'(v_o[d]), int'(edge_cnt >= stg(d) + 1));
            while (sbq[d].size() > 0 && sbq[d][0].due == edge_cnt) begin
                sb_t e;
                e = sbq[d].pop_front();
                chk("binary_pointer", d, int'(b_o[d]), int'(e.bin));
                chk("delta", d, int'(d_o[d]), int'(e.delta));
                chk("pointer_changed", d, int'(c_o[d]), int'(e.chg));
            end
            // The gray output leads the binary register by exactly one edge.
            if (sbq[d].size() > 0 && sbq[d][0].due == edge_cnt + 1) begin
                chk("gray_pointer", d, int'(g_o[d]), int'(sbq[d][0].gray));
            end
        end
    endtask

    task automatic step(input logic [3:0] g, input logic [3:0] eb, input logic [3:0] ed,
                        input logic ec, input bit push);
        gray_in = g;
        if (push) begin
            for (int d = 0; d < 2; d++) begin
                sbq[d].push_back('{gray: g, bin: eb, delta: ed, chg: ec, due: edge_cnt + 1 + stg(d)});
            end
        end
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, " gray_pointer"}, d, int'(g_o[d]), 0);
            chk({tag, " binary_pointer"}, d, int'(b_o[d]), 0);
            chk({tag, " delta"}, d, int'(d_o[d]), 0);
            chk({tag, " pointer_changed"}, d, int'(c_o[d]), 0);
            chk({tag, " sync_valid"}, d, int'(v_o[d]), 0);
        end
    endtask

    initial begin
        // {gray in, expected binary, expected delta, expected changed}; previous value 0 after reset.
        vecs.push_back('{4'b0001,  1, 1, 1});
        vecs.push_back('{4'b0001,  1, 0, 0});
        vecs.push_back('{4'b0011,  2, 1, 1});
        vecs.push_back('{4'b0010,  3, 1, 1});
        vecs.push_back('{4'b0110,  4, 1, 1});
        vecs.push_back('{4'b0111,  5, 1, 1});
        vecs.push_back('{4'b0101,  6, 1, 1});
        vecs.push_back('{4'b0100,  7, 1, 1});
        vecs.push_back('{4'b1100,  8, 1, 1});
        vecs.push_back('{4'b1101,  9, 1, 1});
        vecs.push_back('{4'b1111, 10, 1, 1});
        vecs.push_back('{4'b1110, 11, 1, 1});
        vecs.push_back('{4'b1010, 12, 1, 1});
        vecs.push_back('{4'b1011, 13, 1, 1});
        vecs.push_back('{4'b1001, 14, 1, 1});
        vecs.push_back('{4'b1000, 15, 1, 1});
        vecs.push_back('{4'b0000,  0, 1, 1});
        vecs.push_back('{4'b0001,  1, 1, 1});
        vecs.push_back('{4'b0111,  5, 4, 1});
        vecs.push_back('{4'b0111,  5, 0, 0});
        vecs.push_back('{4'b1000, 15, 10, 1});
        vecs.push_back('{4'b0101,  6, 7, 1});
        vecs.push_back('{4'b0101,  6, 0, 0});

        // Held in reset with a live input: nothing may leak through.
        rst     = 1'b1;
        gray_in = 4'b0101;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_all_zero("in-reset");
        rst      = 1'b0;
        edge_cnt = 0;

        foreach (vecs[i]) begin
            step(vecs[i].gray, vecs[i].bin, vecs[i].delta, vecs[i].chg, 1'b1);
        end

        // Stable input: no pulses, zero delta.
        for (int i = 0; i < 20; i++) begin
            step(4'b0101, 4'd6, 4'd0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            step(4'b0101, 4'd6, 4'd0, 1'b0, 1'b0);
        end

        // Asynchronous reset between edges while the binary pointer sits at 6.
        chk("pre-reset binary_pointer", 0, int'(b_o[0]), 6);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("async-reset");
        for (int d = 0; d < 2; d++) begin
            sbq[d].delete();
        end
        @(negedge clk);
        rst      = 1'b0;
        edge_cnt = 0;

        // Fresh start from the held input: first update is measured against 0.
        step(4'b0101, 4'd6, 4'd6, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(4'b0101, 4'd6, 4'd0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            step(4'b0101, 4'd6, 4'd0, 1'b0, 1'b0);
        end

        for (int d = 0; d < 2; d++) begin
            chk("scoreboard drained", d, sbq[d].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
